// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and helpers for the FFT butterfly datapath
//
// Purpose: default component widths, Q1.x twiddle constants, complex
// pack/unpack helpers (upper half = real part) and a generic saturate.
// Ports: none (package).
package fft_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 24;
  localparam int DEFAULT_TWIDDLE_WIDTH = 24;

  // Q1.23 twiddle constants: ONE is the closest representable value to +1.0
  localparam logic [DEFAULT_TWIDDLE_WIDTH-1:0] ONE       = 24'h7FFFFF;
  localparam logic [DEFAULT_TWIDDLE_WIDTH-1:0] MINUS_ONE = 24'h800000;

  function automatic logic signed [DEFAULT_DATA_WIDTH-1:0] cplx_re(
    input logic [2*DEFAULT_DATA_WIDTH-1:0] c
  );
    return c[2*DEFAULT_DATA_WIDTH-1:DEFAULT_DATA_WIDTH];
  endfunction

  function automatic logic signed [DEFAULT_DATA_WIDTH-1:0] cplx_im(
    input logic [2*DEFAULT_DATA_WIDTH-1:0] c
  );
    return c[DEFAULT_DATA_WIDTH-1:0];
  endfunction

  function automatic logic [2*DEFAULT_DATA_WIDTH-1:0] cplx_pack(
    input logic [DEFAULT_DATA_WIDTH-1:0] re,
    input logic [DEFAULT_DATA_WIDTH-1:0] im
  );
    return {re, im};
  endfunction

  // Clamp a signed value into the two's complement range of 'width' bits.
  // Caller truncates the 64-bit result to 'width' bits.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] x,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/fft_cmult.sv
// rtl/fft_cmult.sv - two-stage pipelined complex multiply W*B with rounding
//
// Purpose: stage 1 registers the four partial products, stage 2 combines
// them, rounds half up and drops the Q1.x fraction bits.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   data_b   in   B = {re, im}, signed DATA_WIDTH each
//   twiddle  in   W = {re, im}, signed Q1.(TWIDDLE_WIDTH-1) each
//   prod_re  out  real part of W*B, DATA_WIDTH+1 bits, 2 clocks after inputs
//   prod_im  out  imaginary part of W*B, DATA_WIDTH+1 bits
module fft_cmult
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int TWIDDLE_WIDTH = DEFAULT_TWIDDLE_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*DATA_WIDTH-1:0]       data_b,
  input  logic [2*TWIDDLE_WIDTH-1:0]    twiddle,
  output logic signed [DATA_WIDTH:0]    prod_re,
  output logic signed [DATA_WIDTH:0]    prod_im
);

  localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH;
  localparam int SW = PW + 1;
  // 2^(TW-2): half an LSB of the result once TW-1 fraction bits are dropped
  localparam logic signed [SW-1:0] RND =
    {{(SW-TWIDDLE_WIDTH+1){1'b0}}, 1'b1, {(TWIDDLE_WIDTH-2){1'b0}}};

  logic signed [DATA_WIDTH-1:0]    b_re, b_im;
  logic signed [TWIDDLE_WIDTH-1:0] w_re, w_im;
  logic signed [PW-1:0]            p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0]            sum_re, sum_im;
  logic                            unused_bits;

  assign b_re = data_b[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_im = data_b[DATA_WIDTH-1:0];
  assign w_re = twiddle[2*TWIDDLE_WIDTH-1:TWIDDLE_WIDTH];
  assign w_im = twiddle[TWIDDLE_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      p_rr <= PW'(b_re) * PW'(w_re);
      p_ii <= PW'(b_im) * PW'(w_im);
      p_ri <= PW'(b_re) * PW'(w_im);
      p_ir <= PW'(b_im) * PW'(w_re);
    end
  end

  assign sum_re = SW'(p_rr) - SW'(p_ii) + RND;
  assign sum_im = SW'(p_ri) + SW'(p_ir) + RND;

  // The arithmetic shift by TW-1 is a slice; only DW+1 bits are kept, which
  // is enough for W=-1 times B=-max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_re <= '0;
      prod_im <= '0;
    end else begin
      prod_re <= sum_re[TWIDDLE_WIDTH-1+DATA_WIDTH:TWIDDLE_WIDTH-1];
      prod_im <= sum_im[TWIDDLE_WIDTH-1+DATA_WIDTH:TWIDDLE_WIDTH-1];
    end
  end

  assign unused_bits = ^{sum_re[SW-1], sum_re[TWIDDLE_WIDTH-2:0],
                         sum_im[SW-1], sum_im[TWIDDLE_WIDTH-2:0]};

endmodule

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - pipelined radix-2 DIT butterfly A +/- W*B, 3-clock latency
//
// Purpose: one butterfly per clock; fft_cmult forms W*B over two stages while
// A is delayed to match, then stage 3 adds/subtracts and saturates.
// Optional build macro FFT_BFLY_SCALE_EN halves the stage-3 result (round
// half up) before saturation; undefined gives the unscaled result.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   i_start       in   input valid for i_data_a, i_data_b, i_twiddle
//   i_data_a      in   A = {re, im}, signed DATA_WIDTH each
//   i_data_b      in   B, same packing
//   i_twiddle     in   W = {re, im}, signed Q1.(TWIDDLE_WIDTH-1)
//   o_data_a_out  out  A + W*B, held while o_valid is low
//   o_data_b_out  out  A - W*B, held while o_valid is low
//   o_valid       out  one-cycle pulse per accepted i_start
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int TWIDDLE_WIDTH = DEFAULT_TWIDDLE_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic [2*DATA_WIDTH-1:0]      i_data_a,
  input  logic [2*DATA_WIDTH-1:0]      i_data_b,
  input  logic [2*TWIDDLE_WIDTH-1:0]   i_twiddle,
  output logic [2*DATA_WIDTH-1:0]      o_data_a_out,
  output logic [2*DATA_WIDTH-1:0]      o_data_b_out,
  output logic                         o_valid
);

  localparam int XW = DATA_WIDTH + 2;

  logic [2:0]                   valid_pipe;
  logic [2*DATA_WIDTH-1:0]      a_d1, a_d2;
  logic signed [DATA_WIDTH:0]   prod_re, prod_im;
  logic signed [DATA_WIDTH-1:0] a_re, a_im;
  logic signed [XW-1:0]         sum_re, sum_im, dif_re, dif_im;

  fft_cmult #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TWIDDLE_WIDTH (TWIDDLE_WIDTH)
  ) u_cmult (
    .clk     (clk),
    .reset   (reset),
    .data_b  (i_data_b),
    .twiddle (i_twiddle),
    .prod_re (prod_re),
    .prod_im (prod_im)
  );

  // A travels alongside the two multiplier stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_d1 <= '0;
      a_d2 <= '0;
    end else begin
      a_d1 <= i_data_a;
      a_d2 <= a_d1;
    end
  end

  assign a_re   = a_d2[2*DATA_WIDTH-1:DATA_WIDTH];
  assign a_im   = a_d2[DATA_WIDTH-1:0];
  assign sum_re = XW'(a_re) + XW'(prod_re);
  assign sum_im = XW'(a_im) + XW'(prod_im);
  assign dif_re = XW'(a_re) - XW'(prod_re);
  assign dif_im = XW'(a_im) - XW'(prod_im);

  function automatic logic [DATA_WIDTH-1:0] clamp_out(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] y;
`ifdef FFT_BFLY_SCALE_EN
    y = (x + XW'(1)) >>> 1;
`else
    y = x;
`endif
    return DATA_WIDTH'(saturate(64'(y), DATA_WIDTH));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pipe   <= '0;
      o_data_a_out <= '0;
      o_data_b_out <= '0;
    end else begin
      valid_pipe <= {valid_pipe[1:0], i_start};
      if (valid_pipe[1]) begin
        o_data_a_out <= {clamp_out(sum_re), clamp_out(sum_im)};
        o_data_b_out <= {clamp_out(dif_re), clamp_out(dif_im)};
      end
    end
  end

  assign o_valid = valid_pipe[2];

endmodule

// File: tb/tb_fft_butterfly.sv
// tb/tb_fft_butterfly.sv - self-checking bench for fft_butterfly
module tb_fft_butterfly;
  import fft_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int TW = DEFAULT_TWIDDLE_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [2*DW-1:0] i_data_a = '0;
  logic [2*DW-1:0] i_data_b = '0;
  logic [2*TW-1:0] i_twiddle = '0;
  logic [2*DW-1:0] o_data_a_out;
  logic [2*DW-1:0] o_data_b_out;
  logic          o_valid;

  always #5 clk = ~clk;

  fft_butterfly #(
    .DATA_WIDTH    (DW),
    .TWIDDLE_WIDTH (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .i_twiddle    (i_twiddle),
    .o_data_a_out (o_data_a_out),
    .o_data_b_out (o_data_b_out),
    .o_valid      (o_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
  } exp_t;

  exp_t          expq[$];
  logic [2*DW-1:0] last_a = '0;
  logic [2*DW-1:0] last_b = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic longint wrap(input longint x, input int n);
    longint m;
    m = x & ((longint'(1) << n) - 1);
    if (m >= (longint'(1) << (n - 1))) m = m - (longint'(1) << n);
    return m;
  endfunction

  function automatic longint fin(input longint x);
    longint y;
    longint hi;
    longint lo;
`ifdef FFT_BFLY_SCALE_EN
    y = (x + 1) >>> 1;
`else
    y = x;
`endif
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  // Reference: exact integer complex arithmetic, round-half-up of W*B, keep
  // DW+1 bits, then A +/- that, optional halving, clamp.
  task automatic model(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                       input logic [2*TW-1:0] w,
                       output logic [2*DW-1:0] ao, output logic [2*DW-1:0] bo);
    longint ar, ai, br, bi, wr, wi, pr, pi, r0, r1, r2, r3;
    logic [2*TW-1:0] wv;
    logic signed [TW-1:0] wrs, wis;
    wv  = w;
    wrs = wv[2*TW-1:TW];
    wis = wv[TW-1:0];
    ar = longint'(cplx_re(a));
    ai = longint'(cplx_im(a));
    br = longint'(cplx_re(b));
    bi = longint'(cplx_im(b));
    wr = longint'(wrs);
    wi = longint'(wis);
    pr = wrap((br * wr - bi * wi + (longint'(1) << (TW - 2))) >>> (TW - 1), DW + 1);
    pi = wrap((br * wi + bi * wr + (longint'(1) << (TW - 2))) >>> (TW - 1), DW + 1);
    r0 = fin(ar + pr);
    r1 = fin(ai + pi);
    r2 = fin(ar - pr);
    r3 = fin(ai - pi);
    ao = cplx_pack(r0[DW-1:0], r1[DW-1:0]);
    bo = cplx_pack(r2[DW-1:0], r3[DW-1:0]);
  endtask

  // Drive one cycle of inputs just after the rising edge; a start is due on
  // the output 3 clocks later.
  task automatic step(input logic st, input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                      input logic [2*TW-1:0] w, input logic [2*DW-1:0] ea,
                      input logic [2*DW-1:0] eb);
    @(posedge clk);
    #1;
    i_start   = st;
    i_data_a  = a;
    i_data_b  = b;
    i_twiddle = w;
    if (st) expq.push_back('{due: cyc + 3, a: ea, b: eb});
  endtask

  task automatic step_lit(input string name, input logic [2*DW-1:0] a,
                          input logic [2*DW-1:0] b, input logic [2*TW-1:0] w,
                          input logic [2*DW-1:0] ea, input logic [2*DW-1:0] eb);
    logic [2*DW-1:0] ma, mb;
    model(a, b, w, ma, mb);
    chk({name, "_model_a"}, 64'(ma), 64'(ea));
    chk({name, "_model_b"}, 64'(mb), 64'(eb));
    step(1'b1, a, b, w, ea, eb);
  endtask

  function automatic logic [DW-1:0] rnd24();
    case ($urandom_range(0, 5))
      0: return 24'h7FFFFF;
      1: return 24'h800000;
      2: return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic step_rand(input logic st);
    logic [2*DW-1:0] a, b, ea, eb;
    logic [2*TW-1:0] w;
    a = {rnd24(), rnd24()};
    b = {rnd24(), rnd24()};
    w = {rnd24(), rnd24()};
    model(a, b, w, ea, eb);
    step(st, a, b, w, ea, eb);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].due == cyc) begin
      chk("o_valid_pulse", 64'(o_valid), 64'd1);
      chk("o_data_a_out", 64'(o_data_a_out), 64'(expq[0].a));
      chk("o_data_b_out", 64'(o_data_b_out), 64'(expq[0].b));
      last_a = expq[0].a;
      last_b = expq[0].b;
      void'(expq.pop_front());
    end else begin
      chk("o_valid_idle", 64'(o_valid), 64'd0);
      chk("hold_a", 64'(o_data_a_out), 64'(last_a));
      chk("hold_b", 64'(o_data_b_out), 64'(last_b));
    end
  end

  logic [2*DW-1:0] e1a, e1b, e2a, e2b, e4a, e4b;

  initial begin
`ifdef FFT_BFLY_SCALE_EN
    e1a = {24'd1500, 24'd0};
    e1b = {24'd500, 24'd0};
    e2a = {24'd750, 24'd250};
    e2b = {24'd250, 24'd750};
`else
    e1a = {24'd3000, 24'd0};
    e1b = {24'd1000, 24'd0};
    e2a = {24'd1500, 24'd500};
    e2b = {24'd500, 24'd1500};
`endif
    e4a = {24'h7FFFFF, 24'd0};
    e4b = {24'd1, 24'd0};

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_a", 64'(o_data_a_out), 64'd0);
    chk("reset_b", 64'(o_data_b_out), 64'd0);
    reset = 1'b1;

    step_lit("identity", {24'd2000, 24'd0}, {24'd1000, 24'd0}, {ONE, 24'd0}, e1a, e1b);
    repeat (4) step_rand(1'b0);
    step_lit("rot_minus_j", {24'd1000, 24'd1000}, {24'd500, 24'd500}, {24'd0, MINUS_ONE},
             e2a, e2b);
    step_lit("zero", '0, '0, '0, '0, '0);
    step_lit("saturate", {24'h7FFFFF, 24'd0}, {24'h7FFFFF, 24'd0}, {ONE, 24'd0}, e4a, e4b);
    repeat (5) step_rand(1'b0);

    // back-to-back throughput
    repeat (4) step_rand(1'b1);
    repeat (5) step_rand(1'b0);

    // reset one cycle after the last start flushes everything in flight
    repeat (4) step_rand(1'b1);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    reset   = 1'b0;
    expq.delete();
    last_a = '0;
    last_b = '0;
    #1;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_a", 64'(o_data_a_out), 64'd0);
    chk("flush_b", 64'(o_data_b_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) step_rand(1'b0);

    // random mix of starts and idle cycles
    for (int i = 0; i < 400; i++) step_rand(1'($urandom_range(0, 1)));
    repeat (6) step_rand(1'b0);

    chk("drain_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
